// File: rtl/gen_reg_file.sv
// General-purpose register file with per-register load/arith/shift ops
// and two independent combinational read ports.
module gen_reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SAT   = 0,
    localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             En,
    input  logic [2:0]       FunSel,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [WIDTH-1:0] I,
    input  logic [SW-1:0]    O1Sel,
    input  logic [SW-1:0]    O2Sel,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic             Z1,
    output logic             Z2,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] nxt  [DEPTH];
    logic [DEPTH-1:0] hit;
    logic             ovf_q;

    // Candidate next value and overflow event for every register
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            nxt[k] = regs[k];
            hit[k] = 1'b0;
            unique case (FunSel)
                3'b000: nxt[k] = regs[k];
                3'b001: nxt[k] = '0;
                3'b010: nxt[k] = I;
                3'b011: begin
                    if (regs[k] == ONES) begin
                        hit[k] = 1'b1;
                        nxt[k] = (SAT != 0) ? ONES : '0;
                    end else begin
                        nxt[k] = regs[k] + ONE;
                    end
                end
                3'b100: begin
                    if (regs[k] == '0) begin
                        hit[k] = 1'b1;
                        nxt[k] = (SAT != 0) ? '0 : ONES;
                    end else begin
                        nxt[k] = regs[k] - ONE;
                    end
                end
                3'b101: begin
                    hit[k] = regs[k][WIDTH-1];
                    nxt[k] = {regs[k][WIDTH-2:0], 1'b0};
                end
                3'b110: begin
                    hit[k] = regs[k][0];
                    nxt[k] = {1'b0, regs[k][WIDTH-1:1]};
                end
                3'b111: begin
                    nxt[k] = {regs[k][WIDTH-2:0], regs[k][WIDTH-1]};
                end
            endcase
        end
    end

    // Register array and event flag; unselected registers hold
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            ovf_q <= 1'b0;
        end else if (En) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (RegSel[k]) regs[k] <= nxt[k];
            end
            ovf_q <= |(hit & RegSel);
        end else begin
            ovf_q <= 1'b0;
        end
    end

    // Read ports; out-of-range indices read as zero
    always_comb begin
        O1 = '0;
        O2 = '0;
        if (int'(O1Sel) < DEPTH) O1 = regs[O1Sel];
        if (int'(O2Sel) < DEPTH) O2 = regs[O2Sel];
        Z1 = (O1 == '0);
        Z2 = (O2 == '0);
    end

    assign Ovf = ovf_q;

endmodule

// File: tb/tb_gen_reg_file.sv
// Directed bench for gen_reg_file: default, saturating, 16x16 and
// non-power-of-two instances driven from one shared stimulus bus.
module tb_gen_reg_file;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  fs = '0;
    logic [15:0] rs = '0;
    logic [15:0] din = '0;
    logic [3:0]  s1 = '0;
    logic [3:0]  s2 = '0;

    logic [7:0]  a_o1, a_o2, b_o1, b_o2, c_o1, c_o2;
    logic [15:0] d_o1, d_o2;
    logic        a_z1, a_z2, a_ovf, b_z1, b_z2, b_ovf;
    logic        c_z1, c_z2, c_ovf, d_z1, d_z2, d_ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    gen_reg_file #(.WIDTH(8), .DEPTH(8), .SAT(0)) u_a (
        .CLK(CLK), .Reset_n(Reset_n), .En(en), .FunSel(fs),
        .RegSel(rs[7:0]), .I(din[7:0]), .O1Sel(s1[2:0]), .O2Sel(s2[2:0]),
        .O1(a_o1), .O2(a_o2), .Z1(a_z1), .Z2(a_z2), .Ovf(a_ovf));

    gen_reg_file #(.WIDTH(8), .DEPTH(8), .SAT(1)) u_b (
        .CLK(CLK), .Reset_n(Reset_n), .En(en), .FunSel(fs),
        .RegSel(rs[7:0]), .I(din[7:0]), .O1Sel(s1[2:0]), .O2Sel(s2[2:0]),
        .O1(b_o1), .O2(b_o2), .Z1(b_z1), .Z2(b_z2), .Ovf(b_ovf));

    gen_reg_file #(.WIDTH(8), .DEPTH(6), .SAT(0)) u_c (
        .CLK(CLK), .Reset_n(Reset_n), .En(en), .FunSel(fs),
        .RegSel(rs[5:0]), .I(din[7:0]), .O1Sel(s1[2:0]), .O2Sel(s2[2:0]),
        .O1(c_o1), .O2(c_o2), .Z1(c_z1), .Z2(c_z2), .Ovf(c_ovf));

    gen_reg_file #(.WIDTH(16), .DEPTH(16), .SAT(0)) u_d (
        .CLK(CLK), .Reset_n(Reset_n), .En(en), .FunSel(fs),
        .RegSel(rs), .I(din), .O1Sel(s1), .O2Sel(s2),
        .O1(d_o1), .O2(d_o2), .Z1(d_z1), .Z2(d_z2), .Ovf(d_ovf));

    typedef struct {
        logic        en;
        logic [2:0]  fs;
        logic [15:0] rs;
        logic [7:0]  din;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [7:0]  o1;
        logic [7:0]  o2;
        logic        ovf;
    } vec_t;

    localparam logic [2:0] HLD = 3'd0, CLR = 3'd1, LD = 3'd2, INC = 3'd3;
    localparam logic [2:0] DEC = 3'd4, SHL = 3'd5, SHR = 3'd6, ROL = 3'd7;

    vec_t vt [24];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic e, input logic [2:0] f,
                         input logic [15:0] r, input logic [15:0] d,
                         input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        en = e; fs = f; rs = r; din = d; s1 = a; s2 = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset_n = 1'b0;
        en = 1'b0; fs = HLD; rs = '0; din = '0;
        #2;
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    initial begin
        //         en fs   rs      din    s1 s2  o1     o2     ovf
        vt[0]  = '{1, LD,  16'h05, 8'hAA, 0, 2, 8'hAA, 8'hAA, 0};
        vt[1]  = '{1, HLD, 16'h00, 8'h00, 1, 3, 8'h00, 8'h00, 0};
        vt[2]  = '{1, LD,  16'h08, 8'hFF, 3, 0, 8'hFF, 8'hAA, 0};
        vt[3]  = '{1, INC, 16'h08, 8'h00, 3, 3, 8'h00, 8'h00, 1};
        vt[4]  = '{1, DEC, 16'h08, 8'h00, 3, 3, 8'hFF, 8'hFF, 1};
        vt[5]  = '{1, HLD, 16'h08, 8'h00, 3, 3, 8'hFF, 8'hFF, 0};
        vt[6]  = '{1, LD,  16'h01, 8'h81, 0, 2, 8'h81, 8'hAA, 0};
        vt[7]  = '{1, SHL, 16'h01, 8'h00, 0, 2, 8'h02, 8'hAA, 1};
        vt[8]  = '{1, SHR, 16'h01, 8'h00, 0, 2, 8'h01, 8'hAA, 0};
        vt[9]  = '{1, LD,  16'h01, 8'h81, 0, 2, 8'h81, 8'hAA, 0};
        vt[10] = '{1, ROL, 16'h01, 8'h00, 0, 2, 8'h03, 8'hAA, 0};
        vt[11] = '{1, LD,  16'h10, 8'h03, 4, 5, 8'h03, 8'h00, 0};
        vt[12] = '{1, LD,  16'h20, 8'h09, 4, 5, 8'h03, 8'h09, 0};
        vt[13] = '{1, INC, 16'h30, 8'h00, 4, 5, 8'h04, 8'h0A, 0};
        vt[14] = '{0, LD,  16'hFF, 8'h77, 0, 3, 8'h03, 8'hFF, 0};
        vt[15] = '{1, SHL, 16'h08, 8'h00, 3, 0, 8'hFE, 8'h03, 1};
        vt[16] = '{1, INC, 16'h00, 8'h00, 3, 0, 8'hFE, 8'h03, 0};
        vt[17] = '{1, SHR, 16'h01, 8'h00, 0, 3, 8'h01, 8'hFE, 1};
        vt[18] = '{0, HLD, 16'h00, 8'h00, 0, 3, 8'h01, 8'hFE, 0};
        vt[19] = '{1, CLR, 16'h09, 8'h00, 0, 3, 8'h00, 8'h00, 0};
        vt[20] = '{1, HLD, 16'h00, 8'h00, 2, 7, 8'hAA, 8'h00, 0};
        vt[21] = '{1, SHL, 16'h04, 8'h00, 2, 2, 8'h54, 8'h54, 1};
        vt[22] = '{1, ROL, 16'h04, 8'h00, 2, 2, 8'hA8, 8'hA8, 0};
        vt[23] = '{1, SHR, 16'h14, 8'h00, 2, 4, 8'h54, 8'h02, 0};

        // Reset state across instances
        do_reset();
        #1;
        chk("rst a_o1", 16'(a_o1), 16'h0);
        chk("rst a_z1", 16'(a_z1), 16'h1);
        chk("rst a_ovf", 16'(a_ovf), 16'h0);
        chk("rst d_o2", d_o2, 16'h0);

        // Table-driven sweep on the default instance
        for (int i = 0; i < 24; i++) begin
            apply(vt[i].en, vt[i].fs, vt[i].rs, 16'(vt[i].din),
                  vt[i].s1, vt[i].s2);
            chk($sformatf("v%0d o1", i), 16'(a_o1), 16'(vt[i].o1));
            chk($sformatf("v%0d o2", i), 16'(a_o2), 16'(vt[i].o2));
            chk($sformatf("v%0d z1", i), 16'(a_z1), 16'(vt[i].o1 == 8'h0));
            chk($sformatf("v%0d z2", i), 16'(a_z2), 16'(vt[i].o2 == 8'h0));
            chk($sformatf("v%0d ovf", i), 16'(a_ovf), 16'(vt[i].ovf));
        end

        // Wrap vs clamp on R1 side by side
        do_reset();
        apply(1, LD, 16'h02, 16'h00FF, 1, 1);
        chk("sat ld b", 16'(b_o1), 16'hFF);
        apply(1, INC, 16'h02, 16'h0, 1, 1);
        chk("sat inc b", 16'(b_o1), 16'hFF);
        chk("sat inc b ovf", 16'(b_ovf), 16'h1);
        chk("wrap inc a", 16'(a_o1), 16'h00);
        chk("wrap inc a ovf", 16'(a_ovf), 16'h1);
        apply(1, CLR, 16'h02, 16'h0, 1, 1);
        chk("sat clr b", 16'(b_o1), 16'h00);
        chk("sat clr b ovf", 16'(b_ovf), 16'h0);
        apply(1, DEC, 16'h02, 16'h0, 1, 1);
        chk("sat dec b", 16'(b_o1), 16'h00);
        chk("sat dec b z", 16'(b_z1), 16'h1);
        chk("sat dec b ovf", 16'(b_ovf), 16'h1);
        chk("wrap dec a", 16'(a_o1), 16'hFF);
        apply(0, HLD, 16'h02, 16'h0, 1, 1);
        chk("en0 clears ovf", 16'(b_ovf), 16'h0);

        // 16-bit wide, 16-deep instance
        do_reset();
        apply(1, LD, 16'h0008, 16'hFFFF, 3, 15);
        chk("w16 ld", d_o1, 16'hFFFF);
        apply(1, INC, 16'h0008, 16'h0, 3, 15);
        chk("w16 inc", d_o1, 16'h0000);
        chk("w16 inc ovf", 16'(d_ovf), 16'h1);
        apply(1, DEC, 16'h0008, 16'h0, 3, 15);
        chk("w16 dec", d_o1, 16'hFFFF);
        chk("w16 dec ovf", 16'(d_ovf), 16'h1);
        apply(1, HLD, 16'h0008, 16'h0, 3, 15);
        chk("w16 hold ovf", 16'(d_ovf), 16'h0);
        apply(1, LD, 16'h8000, 16'h1234, 3, 15);
        chk("w16 r15", d_o2, 16'h1234);
        chk("w16 r3 kept", d_o1, 16'hFFFF);

        // Out-of-range reads on the 6-deep instance
        apply(1, LD, 16'h00FF, 16'h0055, 5, 7);
        chk("oor in range", 16'(c_o1), 16'h55);
        chk("oor o2", 16'(c_o2), 16'h00);
        chk("oor z2", 16'(c_z2), 16'h1);
        apply(1, HLD, 16'h0, 16'h0, 6, 0);
        chk("oor sel6", 16'(c_o1), 16'h00);
        chk("oor sel6 z", 16'(c_z1), 16'h1);

        // Pre-edge read, then asynchronous reset mid-cycle
        do_reset();
        apply(1, LD, 16'h00FF, 16'h0055, 0, 5);
        chk("all55 o1", 16'(a_o1), 16'h55);
        chk("all55 o2", 16'(a_o2), 16'h55);
        @(negedge CLK);
        fs = LD; din = 16'h0066; rs = 16'h00FF; en = 1'b1;
        #1;
        chk("pre-edge o1", 16'(a_o1), 16'h55);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async o1", 16'(a_o1), 16'h00);
        chk("async o2", 16'(a_o2), 16'h00);
        chk("async z1", 16'(a_z1), 16'h1);
        chk("async z2", 16'(a_z2), 16'h1);
        chk("async ovf", 16'(a_ovf), 16'h0);
        @(posedge CLK);
        #1;
        chk("in-reset ignore", 16'(a_o1), 16'h00);
        @(negedge CLK);
        Reset_n = 1'b1;
        din = 16'h0012; rs = 16'h0001; s1 = 4'd0;
        @(posedge CLK);
        #1;
        chk("first edge op", 16'(a_o1), 16'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
